// File: rtl/bcd_event_counter_pkg.sv
// Shared constants for the BCD counter and the downstream display stage.
package bcd_event_counter_pkg;
  localparam int                BCD_W     = 4;
  localparam logic [BCD_W-1:0]  BCD_MAX   = 4'd9;
  localparam int                NDIG      = 4;
  localparam int                DIG_BUS_W = NDIG * BCD_W;
  localparam int                NBTN      = 3;
  localparam int                SW_W      = 8;

  typedef enum logic [1:0] {
    BTN_INC  = 2'd0,
    BTN_DEC  = 2'd1,
    BTN_LOAD = 2'd2
  } btn_e;

  typedef logic [NDIG-1:0][BCD_W-1:0] bcd_vec_t;
endpackage

// File: rtl/bcd_event_counter_if.sv
// Button/switch inputs and digit-bus outputs of the BCD event counter.
interface bcd_event_counter_if;
  import bcd_event_counter_pkg::*;

  logic                 btn_inc;
  logic                 btn_dec;
  logic                 btn_load;
  logic [SW_W-1:0]      sw;
  logic [DIG_BUS_W-1:0] digits;
  logic                 wrap;
  logic                 borrow;
  logic                 upd;

  modport master (
    output btn_inc, btn_dec, btn_load, sw,
    input  digits, wrap, borrow, upd
  );

  modport slave (
    input  btn_inc, btn_dec, btn_load, sw,
    output digits, wrap, borrow, upd
  );
endinterface

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF sync -> debounce -> single-cycle pulse on accepted rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 19
) (
  input  logic clk,
  input  logic clr,
  input  logic i_btn,
  output logic o_pulse
);
  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [DEB_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_q <= r_level;
      // Any agreement with the accepted level restarts the stability window.
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + DEB_W'(1);
      end
    end
  end

  assign o_pulse = r_level & ~r_level_q;
endmodule

// File: rtl/bcd_event_counter.sv
// 4-digit packed-BCD up/down counter with clamped parallel load, driven by debounced buttons.
module bcd_event_counter
  import bcd_event_counter_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 19
) (
  input  logic                 clk,
  input  logic                 clr,
  bcd_event_counter_if.slave   bus
);
  logic [NBTN-1:0] w_raw;
  logic [NBTN-1:0] w_evt;

  assign w_raw[BTN_INC]  = bus.btn_inc;
  assign w_raw[BTN_DEC]  = bus.btn_dec;
  assign w_raw[BTN_LOAD] = bus.btn_load;

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_W      (DEB_W)
    ) u_deb (
      .clk     (clk),
      .clr     (clr),
      .i_btn   (w_raw[g]),
      .o_pulse (w_evt[g])
    );
  end

  function automatic logic [BCD_W-1:0] clamp9(input logic [BCD_W-1:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

  bcd_vec_t r_digits;
  bcd_vec_t w_inc_val;
  bcd_vec_t w_dec_val;
  bcd_vec_t w_load_val;
  logic     w_inc_co;
  logic     w_dec_bo;
  logic     r_wrap;
  logic     r_borrow;
  logic     r_upd;

  // Ripple from d0 upward; a carry/borrow surviving past d3 is the roll-over flag.
  always_comb begin
    w_inc_val = r_digits;
    w_dec_val = r_digits;
    w_inc_co  = 1'b1;
    w_dec_bo  = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (w_inc_co) begin
        if (r_digits[i] >= BCD_MAX) begin
          w_inc_val[i] = '0;
        end else begin
          w_inc_val[i] = r_digits[i] + BCD_W'(1);
          w_inc_co     = 1'b0;
        end
      end
      if (w_dec_bo) begin
        if (r_digits[i] == '0) begin
          w_dec_val[i] = BCD_MAX;
        end else begin
          w_dec_val[i] = r_digits[i] - BCD_W'(1);
          w_dec_bo     = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_load_val    = '0;
    w_load_val[1] = clamp9(bus.sw[7:4]);
    w_load_val[0] = clamp9(bus.sw[3:0]);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_digits <= '0;
      r_wrap   <= 1'b0;
      r_borrow <= 1'b0;
      r_upd    <= 1'b0;
    end else begin
      r_wrap   <= 1'b0;
      r_borrow <= 1'b0;
      r_upd    <= 1'b0;
      if (w_evt[BTN_LOAD]) begin
        r_digits <= w_load_val;
        r_upd    <= 1'b1;
      end else if (w_evt[BTN_INC] && !w_evt[BTN_DEC]) begin
        r_digits <= w_inc_val;
        r_wrap   <= w_inc_co;
        r_upd    <= 1'b1;
      end else if (w_evt[BTN_DEC] && !w_evt[BTN_INC]) begin
        r_digits <= w_dec_val;
        r_borrow <= w_dec_bo;
        r_upd    <= 1'b1;
      end
    end
  end

  assign bus.digits = r_digits;
  assign bus.wrap   = r_wrap;
  assign bus.borrow = r_borrow;
  assign bus.upd    = r_upd;
endmodule
